// File: rtl/write_back.sv
// RV32I write-back stage: load formatting, result select, register-file write port,
// one-cycle forwarding hold register and cycle/instret counters with a registered read port.
module write_back #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MEM_WB_valid,
   input  logic [4:0]      MEM_WB_RD,
   input  logic            MEM_WB_regwrite_en,
   input  logic            MEM_WB_wb_sel,
   input  logic [XLEN-1:0] MEM_WB_ALU_OUT,
   input  logic [XLEN-1:0] MEM_WB_LOAD_ALU_OUT,
   input  logic [2:0]      MEM_WB_funct3,
   input  logic [1:0]      cnt_inhibit,
   input  logic [1:0]      cnt_sel,
   output logic [XLEN-1:0] WB_ID_WD3,
   output logic [4:0]      WB_ID_RD_A3,
   output logic            WB_ID_WE3,
   output logic [XLEN-1:0] WB_HOLD_WD,
   output logic [4:0]      WB_HOLD_RD,
   output logic            WB_HOLD_VALID,
   output logic [XLEN-1:0] cnt_rdata
);

   logic [7:0]       word_bytes [4];
   logic [1:0]       off;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
   logic [XLEN-1:0]  load_data;
   logic [CNT_W-1:0] cycle_reg;
   logic [CNT_W-1:0] cycle_next;
   logic [CNT_W-1:0] instret_reg;
   logic [CNT_W-1:0] instret_next;
   logic [XLEN-1:0]  rdata_next;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bytes
         assign word_bytes[gi] = MEM_WB_LOAD_ALU_OUT[8*gi +: 8];
      end
   endgenerate

   assign off = MEM_WB_ALU_OUT[1:0];

   // Unused funct3 codes fall through to a full-word load.
   always_comb begin
      sel_byte  = word_bytes[off];
      sel_half  = off[1] ? MEM_WB_LOAD_ALU_OUT[31:16] : MEM_WB_LOAD_ALU_OUT[15:0];
      load_data = MEM_WB_LOAD_ALU_OUT;
      case (MEM_WB_funct3)
         3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
         3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
         default: load_data = MEM_WB_LOAD_ALU_OUT;
      endcase
   end

   assign WB_ID_WD3   = MEM_WB_wb_sel ? load_data : MEM_WB_ALU_OUT;
   assign WB_ID_RD_A3 = MEM_WB_RD;
   assign WB_ID_WE3   = MEM_WB_valid & MEM_WB_regwrite_en & (MEM_WB_RD != 5'd0);

   always_comb begin
      cycle_next   = cnt_inhibit[0] ? cycle_reg : cycle_reg + CNT_W'(1);
      instret_next = (MEM_WB_valid && !cnt_inhibit[1]) ? instret_reg + CNT_W'(1) : instret_reg;
      case (cnt_sel)
         2'b00:   rdata_next = cycle_reg[0 +: XLEN];
         2'b01:   rdata_next = cycle_reg[XLEN +: XLEN];
         2'b10:   rdata_next = instret_reg[0 +: XLEN];
         default: rdata_next = instret_reg[XLEN +: XLEN];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_HOLD_WD    <= '0;
         WB_HOLD_RD    <= '0;
         WB_HOLD_VALID <= 1'b0;
         cnt_rdata     <= '0;
         cycle_reg     <= '0;
         instret_reg   <= '0;
      end else begin
         WB_HOLD_VALID <= WB_ID_WE3;
         if (WB_ID_WE3) begin
            WB_HOLD_WD <= WB_ID_WD3;
            WB_HOLD_RD <= WB_ID_RD_A3;
         end
         cnt_rdata   <= rdata_next;
         cycle_reg   <= cycle_next;
         instret_reg <= instret_next;
      end
   end

endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed load/ALU table, counter wrap, inhibit, async reset,
// then randomized traffic against an arithmetic reference model.
module tb_write_back;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid, regwrite, wb_sel;
   logic [4:0]  rd;
   logic [31:0] alu_out, load_word;
   logic [2:0]  funct3;
   logic [1:0]  inhibit, sel;
   logic [31:0] wd3, hold_wd, rdata;
   logic [4:0]  ra3, hold_rd;
   logic        we3, hold_valid;

   int vectors = 0;
   int miscompares = 0;
   int txn = 0;

   logic [63:0] m_cycle, m_instret;
   logic [31:0] m_hold_wd, m_rdata;
   logic [4:0]  m_hold_rd;
   logic        m_hold_valid;

   always #5 clk = ~clk;

   write_back dut (
      .clk(clk), .rst(rst),
      .MEM_WB_valid(valid), .MEM_WB_RD(rd), .MEM_WB_regwrite_en(regwrite),
      .MEM_WB_wb_sel(wb_sel), .MEM_WB_ALU_OUT(alu_out), .MEM_WB_LOAD_ALU_OUT(load_word),
      .MEM_WB_funct3(funct3), .cnt_inhibit(inhibit), .cnt_sel(sel),
      .WB_ID_WD3(wd3), .WB_ID_RD_A3(ra3), .WB_ID_WE3(we3),
      .WB_HOLD_WD(hold_wd), .WB_HOLD_RD(hold_rd), .WB_HOLD_VALID(hold_valid),
      .cnt_rdata(rdata)
   );

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] word;
      logic [4:0]  rd;
      logic        valid;
      logic        regwrite;
      logic        wb_sel;
      logic [31:0] exp_wd;
      logic        exp_we;
   } vec_t;

   vec_t table_v[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Load formatting from the byte/halfword rules, using shifts and modular arithmetic.
   function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] word);
      int unsigned b, h;
      b = (word >> (8 * addr[1:0])) % 256;
      h = (word >> (16 * addr[1])) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd();
      return wb_sel ? fmt(funct3, alu_out, load_word) : alu_out;
   endfunction

   function automatic logic exp_we();
      return valid && regwrite && (rd != 0);
   endfunction

   task automatic model_reset();
      m_cycle = 0; m_instret = 0; m_hold_wd = 0; m_hold_rd = 0; m_hold_valid = 0; m_rdata = 0;
   endtask

   task automatic idle_inputs();
      valid = 0; regwrite = 0; wb_sel = 0; rd = 0; alu_out = 0; load_word = 0;
      funct3 = 0; inhibit = 0; sel = 0;
   endtask

   // One clock of traffic: combinational check, edge, registered check; inputs set beforehand.
   task automatic cycle_check();
      #1;
      chk("WD3", wd3, exp_wd());
      chk("RD_A3", ra3, rd);
      chk("WE3", we3, exp_we());
      @(posedge clk);
      case (sel)
         2'd0: m_rdata = m_cycle[31:0];
         2'd1: m_rdata = m_cycle[63:32];
         2'd2: m_rdata = m_instret[31:0];
         default: m_rdata = m_instret[63:32];
      endcase
      m_hold_valid = exp_we();
      if (m_hold_valid) begin
         m_hold_wd = exp_wd();
         m_hold_rd = rd;
      end
      if (!inhibit[0]) m_cycle = m_cycle + 1;
      if (valid && !inhibit[1]) m_instret = m_instret + 1;
      #1;
      chk("HOLD_VALID", hold_valid, m_hold_valid);
      chk("HOLD_WD", hold_wd, m_hold_wd);
      chk("HOLD_RD", hold_rd, m_hold_rd);
      chk("cnt_rdata", rdata, m_rdata);
      $display("txn %0d: wd3=%h we3=%b hold=%0d/%h/%b rdata=%h", txn, wd3, we3,
               hold_rd, hold_wd, hold_valid, rdata);
      txn++;
      @(negedge clk);
   endtask

   initial begin
      table_v[0] = '{"alu",  3'd0, 32'h0000_1234, 32'h0,         5'd5, 1, 1, 0, 32'h0000_1234, 1};
      table_v[1] = '{"lb3",  3'd0, 32'h0000_1003, 32'h80FF_7F01, 5'd6, 1, 1, 1, 32'hFFFF_FF80, 1};
      table_v[2] = '{"lbu1", 3'd4, 32'h0000_1001, 32'h80FF_7F01, 5'd7, 1, 1, 1, 32'h0000_007F, 1};
      table_v[3] = '{"lh2",  3'd1, 32'h0000_1002, 32'h80FF_7F01, 5'd8, 1, 1, 1, 32'hFFFF_80FF, 1};
      table_v[4] = '{"lhu0", 3'd5, 32'h0000_1000, 32'h80FF_7F01, 5'd9, 1, 1, 1, 32'h0000_7F01, 1};
      table_v[5] = '{"lw",   3'd2, 32'h0000_1003, 32'h80FF_7F01, 5'd10, 1, 1, 1, 32'h80FF_7F01, 1};
      table_v[6] = '{"x0",   3'd0, 32'h0000_0055, 32'h0,         5'd0, 1, 1, 0, 32'h0000_0055, 0};

      idle_inputs();
      #1 rst = 1'b1;
      #2;
      chk("rst_HOLD_WD", hold_wd, 0);
      chk("rst_HOLD_VALID", hold_valid, 0);
      chk("rst_cnt_rdata", rdata, 0);
      chk("rst_WE3", we3, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      for (int i = 0; i < 5; i++) cycle_check();

      foreach (table_v[i]) begin
         funct3 = table_v[i].f3; alu_out = table_v[i].addr; load_word = table_v[i].word;
         rd = table_v[i].rd; valid = table_v[i].valid; regwrite = table_v[i].regwrite;
         wb_sel = table_v[i].wb_sel; sel = 2'd2;
         #1;
         chk({"tbl_wd_", table_v[i].name}, wd3, table_v[i].exp_wd);
         chk({"tbl_we_", table_v[i].name}, we3, table_v[i].exp_we);
         cycle_check();
      end

      // Counter wrap: preload cycle with all ones and read the upper half across the edge.
      idle_inputs();
      sel = 2'd1;
      force dut.cycle_reg = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_reg;
      m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle_check();
      chk("wrap_hi_before", rdata, 32'hFFFF_FFFF);
      cycle_check();
      chk("wrap_hi_after", rdata, 32'h0000_0000);

      // Inhibit both counters during three retirements.
      inhibit = 2'b11; valid = 1; regwrite = 1; rd = 5'd3; alu_out = 32'hABCD_0000; sel = 2'd2;
      for (int i = 0; i < 3; i++) cycle_check();
      inhibit = 2'b00; valid = 0;
      cycle_check();
      chk("inhibit_instret", rdata, m_instret[31:0]);

      // Asynchronous reset between edges.
      valid = 1; rd = 5'd4; regwrite = 1; sel = 2'd0;
      cycle_check();
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      chk("arst_HOLD_WD", hold_wd, 0);
      chk("arst_HOLD_RD", hold_rd, 0);
      chk("arst_HOLD_VALID", hold_valid, 0);
      chk("arst_cnt_rdata", rdata, 0);
      chk("arst_WD3", wd3, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) cycle_check();

      for (int i = 0; i < 300; i++) begin
         valid     = ($urandom % 4) != 0;
         regwrite  = ($urandom % 4) != 0;
         wb_sel    = $urandom % 2;
         rd        = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
         alu_out   = $urandom;
         load_word = $urandom;
         funct3    = 3'($urandom);
         inhibit   = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
         sel       = 2'($urandom);
         cycle_check();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final stage of the RV32I pipeline. Sits directly downstream of memory_access and consumes its MEM_WB_* register outputs.
- Formats load data (byte/half extraction, sign/zero extension) and selects the load or ALU result.
- Drives the register-file write port (WB_ID_WD3 / WB_ID_RD_A3 / WB_ID_WE3) back into instruction_decode.
- Also keeps a one-cycle write-back hold register for forwarding, plus 64-bit cycle/instret counters with a registered read port.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of cycle and instret counters

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-high
MEM_WB_valid  input  1  MEM/WB register holds a retiring instruction
MEM_WB_RD  input  5  destination register
MEM_WB_regwrite_en  input  1  instruction writes rd
MEM_WB_wb_sel  input  1  0 = ALU result, 1 = load data
MEM_WB_ALU_OUT  input  32  ALU result; for loads, the effective address
MEM_WB_LOAD_ALU_OUT  input  32  raw aligned word read from data memory
MEM_WB_funct3  input  3  load width/sign code
cnt_inhibit  input  2  bit0 freezes cycle counter, bit1 freezes instret
cnt_sel  input  2  00 cycle[31:0], 01 cycle[63:32], 10 instret[31:0], 11 instret[63:32]
WB_ID_WD3  output  32  register-file write data
WB_ID_RD_A3  output  5  register-file write address
WB_ID_WE3  output  1  register-file write enable
WB_HOLD_WD  output  32  previous cycle's write data (forwarding)
WB_HOLD_RD  output  5  previous cycle's write address
WB_HOLD_VALID  output  1  previous cycle performed a write
cnt_rdata  output  32  selected counter half, registered

Behaviour:
- Clock and reset are fixed: one clock (clk); rst is asynchronous, active-high. All registers clear immediately on rst assertion, independent of clk.
- Reset values: WB_HOLD_WD = 0, WB_HOLD_RD = 0, WB_HOLD_VALID = 0, cnt_rdata = 0, both counters = 0. WB_ID_* are combinational and read 0 while inputs are 0.
- Load formatting is combinational. Byte offset off = MEM_WB_ALU_OUT[1:0].
  - 000 LB: sign-extend byte at bits [8*off+7 : 8*off].
  - 100 LBU: same byte, zero-extended.
  - 001 LH: sign-extend halfword selected by off[1]; off[0] ignored.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word; off ignored.
  - 011, 110, 111: treated as LW.
- Result mux: WB_ID_WD3 = MEM_WB_wb_sel ? formatted_load : MEM_WB_ALU_OUT.
- WB_ID_RD_A3 = MEM_WB_RD.
- WB_ID_WE3 = MEM_WB_valid & MEM_WB_regwrite_en & (MEM_WB_RD != 0). Writes to x0 are always suppressed.
- Write-back path latency: 0 cycles, MEM_WB register to register-file port.
- Hold register, loaded every posedge:
  - WB_HOLD_VALID <= WB_ID_WE3.
  - When WB_ID_WE3 = 1: WB_HOLD_WD <= WB_ID_WD3 and WB_HOLD_RD <= WB_ID_RD_A3.
  - When WB_ID_WE3 = 0: WD/RD retain their old values and only VALID drops.
- Cycle counter:
  - Increments by 1 each posedge unless cnt_inhibit[0].
  - Wraps from 2^64-1 to 0.
- Instret counter:
  - Increments by 1 each posedge where MEM_WB_valid = 1, unless cnt_inhibit[1].
  - Counts retirements regardless of regwrite_en (stores and branches count).
  - Wraps from 2^64-1 to 0.
- Counter read: cnt_rdata <= selected half, sampled at posedge. Latency is 1 cycle. The value returned is the pre-increment value of that edge.
- Simultaneous events: inhibit asserted on the same edge as a retirement means no increment. Changing cnt_sel affects cnt_rdata on the next edge only.
- Reset mid-operation: counters, hold register and cnt_rdata return to 0 asynchronously. Counting resumes on the first posedge after rst deasserts.

Test Plan:
- Reset, then 5 idle cycles with cnt_sel = 00 -> cnt_rdata steps 0,1,2,3,4; instret stays 0; WB_HOLD_VALID = 0.
- ALU writeback: valid=1, regwrite=1, wb_sel=0, RD=5, ALU_OUT=0x0000_1234 -> WD3=0x1234, RD_A3=5, WE3=1; next edge HOLD_RD=5, HOLD_WD=0x1234, HOLD_VALID=1.
- Loads with word 0x80FF_7F01, wb_sel=1:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=1 -> 0x0000_007F.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- x0 suppression: valid=1, regwrite=1, RD=0 -> WE3=0, HOLD_VALID=0 next edge, instret still +1.
- Counter wrap: force cycle to 0xFFFF_FFFF_FFFF_FFFF -> next edge 0; with cnt_sel = 01, cnt_rdata reads 0xFFFF_FFFF then 0x0000_0000.
- Inhibit and mid-run reset: cnt_inhibit=2'b11 with 3 retirements -> both counters unchanged. Assert rst asynchronously between edges -> all outputs 0 immediately.
